data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-port arbiter and sequencer for the data memory block.
- Port A is the processor load/store path; port B is the secondary master (debug/DMA loader).
- Round-robin grant between the two ports.
- Drives a single one-cycle memread/memwrite issue, tracks the memory's clk_stall handshake to completion, and returns read data with a one-cycle ack.
- A stall timeout returns an error so a hung memory cannot lock a requester.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in WAIT_HI+WAIT_LO before abort; legal 4..255.
- CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- a_memread  in  1  port A read request, held until a_ack
- a_memwrite  in  1  port A write request, held until a_ack
- a_addr  in  32  port A byte address
- a_write_data  in  32  port A store data
- a_sign_mask  in  4  port A size/sign code, passed through unchanged
- a_read_data  out  32  port A load data, valid when a_ack=1
- a_ack  out  1  one-cycle completion pulse
- a_err  out  1  one-cycle pulse coincident with a_ack on timeout
- b_*  same seven request/response signals for port B
- mem_addr  out  32  to memory addr
- mem_write_data  out  32  to memory write_data
- mem_memread  out  1  to memory memread
- mem_memwrite  out  1  to memory memwrite
- mem_sign_mask  out  4  to memory sign_mask
- mem_read_data  in  32  from memory read_data
- mem_clk_stall  in  1  from memory clk_stall
- grant_b  out  1  owner of the current or last transaction (0=A, 1=B)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; last-served=B, so A wins the first tie; timeout counter=0.
- Request is defined as memread|memwrite on a port. Both bits high is forwarded as-is; the memory gives read precedence.
- IDLE:
  - Arbitrate only if mem_clk_stall=0. This covers reset released while the memory is still mid-operation.
  - One port requesting: grant it. Both requesting: grant the port not last served.
  - On grant: register addr/write_data/sign_mask/memread/memwrite of the winner onto mem_*; set grant_b; go to ISSUE.
- ISSUE (1 cycle):
  - mem_memread/mem_memwrite high for this cycle only; they are cleared at the exiting edge.
  - mem_addr, mem_write_data and mem_sign_mask are held stable from ISSUE until IDLE is re-entered.
  - Go to WAIT_HI; counter=0.
- WAIT_HI: when mem_clk_stall=1, go to WAIT_LO; otherwise counter+1.
- WAIT_LO: when mem_clk_stall=0, capture mem_read_data into the granted port's read_data and go to DONE; otherwise counter+1.
- Timeout: counter reaching TIMEOUT_CYCLES in either WAIT state forces DONE with err=1 and read_data=0. The memory is not re-issued.
- DONE (1 cycle):
  - Granted port's ack=1 (plus err if timed out); the other port's ack/err=0.
  - Update last-served; go to IDLE.
  - The requester must drop its request at the edge ending the ack cycle. A request seen in IDLE on the following cycle is treated as new.
- Latency, nominal memory (stall high 2 cycles): request high in cycle 0 → ISSUE cycle 1 → stall high cycles 2–3 → stall low cycle 4 → ack cycle 5. Read and write timing is identical.
- Back-to-back: the earliest next grant is the cycle after DONE. Full turnaround is 6 cycles per transaction.
- read_data on each port holds its last captured value until that port's next ack. a_ack and b_ack are never high together.
- Request dropped before ack: protocol violation. A transaction already issued still completes and acks.
- reset_n asserted mid-transaction: immediate return to IDLE with outputs 0. No ack is produced for the aborted transaction.

Test Plan:
- Single A read, addr 0x0000_0010, memory word 0xDEAD_BEEF, sign_mask 4'b0100 → mem_memread high exactly in cycle 1; a_ack in cycle 5; a_read_data=0xDEAD_BEEF; b_ack stays 0.
- Simultaneous A write (0x20, 0x1234_5678) and B read (0x20) from reset → A granted first, B ISSUE in cycle 7, b_read_data=0x1234_5678, grant_b=1 during B.
- A and B both continuously requesting 4 transactions each → grants strictly alternate A,B,A,B…; no port waits more than one transaction.
- Memory model holds clk_stall low forever after issue, TIMEOUT_CYCLES=16 → a_ack and a_err together 17 cycles after ISSUE; a_read_data=0; next request proceeds normally.
- reset_n pulsed low in WAIT_LO while memory stall is still high → outputs 0 immediately; a request held after release is not issued until mem_clk_stall=0, then completes correctly.
- B write with sign_mask 4'b0000 (byte) at addr 0x23 → mem_sign_mask=0, mem_addr=0x23 stable from ISSUE through DONE; mem_memwrite high for exactly one cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the data memory.
// Issues one memread/memwrite pulse, follows clk_stall to completion and acks the owning port.
module data_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_memread,
    input  logic        a_memwrite,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_write_data,
    input  logic [3:0]  a_sign_mask,
    output logic [31:0] a_read_data,
    output logic        a_ack,
    output logic        a_err,

    input  logic        b_memread,
    input  logic        b_memwrite,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_write_data,
    input  logic [3:0]  b_sign_mask,
    output logic [31:0] b_read_data,
    output logic        b_ack,
    output logic        b_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall,

    output logic        grant_b
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_limit;
    logic              last_b;
    logic              last_b_nxt;
    logic              grant_b_nxt;

    logic [31:0]       mem_addr_nxt;
    logic [31:0]       mem_write_data_nxt;
    logic              mem_memread_nxt;
    logic              mem_memwrite_nxt;
    logic [3:0]        mem_sign_mask_nxt;

    logic [31:0]       a_read_data_nxt;
    logic [31:0]       b_read_data_nxt;
    logic              a_ack_nxt;
    logic              a_err_nxt;
    logic              b_ack_nxt;
    logic              b_err_nxt;

    logic              a_req;
    logic              b_req;
    logic              pick_b;
    logic              finish;
    logic              fin_err;

    assign a_req     = a_memread | a_memwrite;
    assign b_req     = b_memread | b_memwrite;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign cnt_limit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // last_b resets to 1 so port A wins the very first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last_b         <= 1'b1;
            grant_b        <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_sign_mask  <= '0;
            a_read_data    <= '0;
            b_read_data    <= '0;
            a_ack          <= 1'b0;
            a_err          <= 1'b0;
            b_ack          <= 1'b0;
            b_err          <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            last_b         <= last_b_nxt;
            grant_b        <= grant_b_nxt;
            mem_addr       <= mem_addr_nxt;
            mem_write_data <= mem_write_data_nxt;
            mem_memread    <= mem_memread_nxt;
            mem_memwrite   <= mem_memwrite_nxt;
            mem_sign_mask  <= mem_sign_mask_nxt;
            a_read_data    <= a_read_data_nxt;
            b_read_data    <= b_read_data_nxt;
            a_ack          <= a_ack_nxt;
            a_err          <= a_err_nxt;
            b_ack          <= b_ack_nxt;
            b_err          <= b_err_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        cnt_nxt            = cnt;
        last_b_nxt         = last_b;
        grant_b_nxt        = grant_b;
        mem_addr_nxt       = mem_addr;
        mem_write_data_nxt = mem_write_data;
        mem_memread_nxt    = mem_memread;
        mem_memwrite_nxt   = mem_memwrite;
        mem_sign_mask_nxt  = mem_sign_mask;
        a_read_data_nxt    = a_read_data;
        b_read_data_nxt    = b_read_data;
        a_ack_nxt          = 1'b0;
        a_err_nxt          = 1'b0;
        b_ack_nxt          = 1'b0;
        b_err_nxt          = 1'b0;
        pick_b             = 1'b0;
        finish             = 1'b0;
        fin_err            = 1'b0;

        case (state)
            // A memory still stalling (e.g. reset released mid-operation) blocks arbitration.
            IDLE: begin
                if (!mem_clk_stall && (a_req || b_req)) begin
                    pick_b             = b_req && (!a_req || !last_b);
                    grant_b_nxt        = pick_b;
                    mem_addr_nxt       = pick_b ? b_addr       : a_addr;
                    mem_write_data_nxt = pick_b ? b_write_data : a_write_data;
                    mem_sign_mask_nxt  = pick_b ? b_sign_mask  : a_sign_mask;
                    mem_memread_nxt    = pick_b ? b_memread    : a_memread;
                    mem_memwrite_nxt   = pick_b ? b_memwrite   : a_memwrite;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                mem_memread_nxt  = 1'b0;
                mem_memwrite_nxt = 1'b0;
                cnt_nxt          = '0;
                state_nxt        = WAIT_HI;
            end
            WAIT_HI: begin
                if (mem_clk_stall) begin
                    state_nxt = WAIT_LO;
                end else if (cnt_limit) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            WAIT_LO: begin
                if (!mem_clk_stall) begin
                    finish = 1'b1;
                end else if (cnt_limit) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            DONE: begin
                last_b_nxt = grant_b;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Ack and read data are registered on the edge entering DONE, so they are valid during DONE.
        if (finish) begin
            state_nxt = DONE;
            if (grant_b) begin
                b_ack_nxt       = 1'b1;
                b_err_nxt       = fin_err;
                b_read_data_nxt = fin_err ? 32'd0 : mem_read_data;
            end else begin
                a_ack_nxt       = 1'b1;
                a_err_nxt       = fin_err;
                a_read_data_nxt = fin_err ? 32'd0 : mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a stalling memory model and a
// transaction-level round-robin reference model.
module tb_data_mem_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_memread, a_memwrite, b_memread, b_memwrite;
    logic [31:0] a_addr, a_write_data, b_addr, b_write_data;
    logic [3:0]  a_sign_mask, b_sign_mask;
    logic [31:0] a_read_data, b_read_data;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] mem_addr, mem_write_data;
    logic        mem_memread, mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = '0;
    logic        mem_clk_stall = 1'b0;
    logic        grant_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem_arr [256];
    logic [31:0] shadow  [256];
    int          stall_len = 2;
    bit          hang      = 1'b0;
    int          stall_cnt = 0;

    logic        op_wr   [2][4];
    logic [31:0] op_addr [2][4];
    logic [31:0] op_data [2][4];
    logic [3:0]  op_mask [2][4];

    data_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_memread(a_memread), .a_memwrite(a_memwrite), .a_addr(a_addr),
        .a_write_data(a_write_data), .a_sign_mask(a_sign_mask),
        .a_read_data(a_read_data), .a_ack(a_ack), .a_err(a_err),
        .b_memread(b_memread), .b_memwrite(b_memwrite), .b_addr(b_addr),
        .b_write_data(b_write_data), .b_sign_mask(b_sign_mask),
        .b_read_data(b_read_data), .b_ack(b_ack), .b_err(b_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    // Memory: on an issue pulse it performs the access and raises stall for stall_len cycles.
    always @(posedge clk) begin
        if (mem_memread || mem_memwrite) begin
            if (mem_memread) mem_read_data <= mem_arr[mem_addr[7:0]];
            else             mem_arr[mem_addr[7:0]] = mem_write_data;
            if (!hang) begin
                mem_clk_stall <= 1'b1;
                stall_cnt     <= stall_len - 1;
            end
        end else if (stall_cnt > 0) begin
            stall_cnt <= stall_cnt - 1;
        end else begin
            mem_clk_stall <= 1'b0;
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        a_memread = 0; a_memwrite = 0; a_addr = '0; a_write_data = '0; a_sign_mask = '0;
        b_memread = 0; b_memwrite = 0; b_addr = '0; b_write_data = '0; b_sign_mask = '0;
        hang = 1'b0;
        stall_len = 2;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic present(input int p, input int i);
        if (p == 0) begin
            a_memread = !op_wr[0][i]; a_memwrite = op_wr[0][i];
            a_addr = op_addr[0][i]; a_write_data = op_data[0][i]; a_sign_mask = op_mask[0][i];
        end else begin
            b_memread = !op_wr[1][i]; b_memwrite = op_wr[1][i];
            b_addr = op_addr[1][i]; b_write_data = op_data[1][i]; b_sign_mask = op_mask[1][i];
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({a_ack, a_err, b_ack, b_err, grant_b, mem_memread, mem_memwrite} !== 7'd0 ||
            {a_read_data, b_read_data, mem_addr, mem_write_data, mem_sign_mask} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_idle: outputs not all zero after reset");
        end
        b_memwrite = 1; b_addr = 32'h44; b_write_data = 32'h5555_AAAA; b_sign_mask = 4'hF;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_addr !== 32'd0 || grant_b !== 1'b0 || mem_sign_mask !== 4'd0 || mem_write_data !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_async: got addr=%h grant_b=%b mask=%h wd=%h required all 0",
                               mem_addr, grant_b, mem_sign_mask, mem_write_data);
        end
        @(negedge clk);
        b_memwrite = 0;
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || b_ack !== 1'b0) begin
                n_fail++; $display("[TB] FAIL reset_quiet: spurious activity rd=%b wr=%b b_ack=%b required 0",
                                   mem_memread, mem_memwrite, b_ack);
            end
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        mem_arr[8'h10] = 32'hDEAD_BEEF;
        a_memread = 1; a_addr = 32'h10; a_sign_mask = 4'b0100;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_memread !== (cyc == 1)) begin
                n_fail++; $display("[TB] FAIL single_issue c%0d: got %b required %b", cyc, mem_memread, cyc == 1);
            end
            n_cmp++;
            if (a_ack !== (cyc == 5) || b_ack !== 1'b0) begin
                n_fail++; $display("[TB] FAIL single_ack c%0d: got a=%b b=%b required a=%b b=0", cyc, a_ack, b_ack, cyc == 5);
            end
            if (cyc == 1) begin
                n_cmp++;
                if (mem_addr !== 32'h10 || mem_sign_mask !== 4'b0100 || grant_b !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL single_fwd: got addr=%h mask=%b grant_b=%b required 10/0100/0",
                                       mem_addr, mem_sign_mask, grant_b);
                end
            end
            if (cyc == 5) begin
                n_cmp++;
                if (a_read_data !== 32'hDEAD_BEEF || a_err !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL single_data: got %h err=%b required deadbeef err=0", a_read_data, a_err);
                end
                a_memread = 0;
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        a_memwrite = 1; a_addr = 32'h20; a_write_data = 32'h1234_5678; a_sign_mask = 4'b0010;
        b_memread = 1; b_addr = 32'h20; b_sign_mask = 4'b0010;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (a_ack !== (cyc == 5) || b_ack !== (cyc == 11)) begin
                n_fail++; $display("[TB] FAIL simul_ack c%0d: got a=%b b=%b required a=%b b=%b",
                                   cyc, a_ack, b_ack, cyc == 5, cyc == 11);
            end
            n_cmp++;
            if (mem_memwrite !== (cyc == 1) || mem_memread !== (cyc == 7)) begin
                n_fail++; $display("[TB] FAIL simul_issue c%0d: got wr=%b rd=%b required wr=%b rd=%b",
                                   cyc, mem_memwrite, mem_memread, cyc == 1, cyc == 7);
            end
            if (cyc == 1 || cyc == 7 || cyc == 9) begin
                n_cmp++;
                if (grant_b !== (cyc != 1)) begin
                    n_fail++; $display("[TB] FAIL simul_grant c%0d: got %b required %b", cyc, grant_b, cyc != 1);
                end
            end
            if (cyc == 5) a_memwrite = 0;
            if (cyc == 11) begin
                n_cmp++;
                if (b_read_data !== 32'h1234_5678) begin
                    n_fail++; $display("[TB] FAIL simul_data: got %h required 12345678", b_read_data);
                end
                b_memread = 0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int          exp_port [8];
        logic        exp_wr   [8];
        logic [31:0] exp_rd   [8];
        int          qi [2];
        int          nxt [2];
        int          last, p, got, last_ack, exp_cyc, lat;
        logic        ack;
        logic [31:0] rd;
        apply_reset();
        stall_len = $urandom_range(1, 4);
        lat = stall_len + 3;
        for (int q = 0; q < 2; q++) begin
            for (int i = 0; i < 4; i++) begin
                op_wr[q][i]   = 1'($urandom_range(0, 1));
                op_addr[q][i] = 32'h80 + 32'(4 * $urandom_range(0, 3));
                op_data[q][i] = $urandom;
                op_mask[q][i] = 4'($urandom_range(0, 15));
            end
        end
        for (int i = 0; i < 256; i++) shadow[i] = mem_arr[i];
        qi[0] = 0; qi[1] = 0; last = 1;
        for (int k = 0; k < 8; k++) begin
            if (qi[0] < 4 && qi[1] < 4) p = 1 - last;
            else                        p = (qi[0] < 4) ? 0 : 1;
            exp_port[k] = p;
            exp_wr[k]   = op_wr[p][qi[p]];
            exp_rd[k]   = shadow[op_addr[p][qi[p]][7:0]];
            if (exp_wr[k]) shadow[op_addr[p][qi[p]][7:0]] = op_data[p][qi[p]];
            qi[p]++;
            last = p;
        end
        present(0, 0); present(1, 0);
        nxt[0] = 1; nxt[1] = 1; got = 0; last_ack = 0;
        for (int cyc = 1; cyc <= 150 && got < 8; cyc++) begin
            @(negedge clk);
            if (a_ack === 1'b1 && b_ack === 1'b1) begin
                n_cmp++; n_fail++; $display("[TB] FAIL b2b_both_ack c%0d: got both acks required one", cyc);
            end
            for (int q = 0; q < 2; q++) begin
                ack = (q == 0) ? a_ack : b_ack;
                rd  = (q == 0) ? a_read_data : b_read_data;
                if (ack === 1'b1) begin
                    n_cmp++;
                    if (got >= 8 || exp_port[got] != q) begin
                        n_fail++; $display("[TB] FAIL b2b_order #%0d: got port %0d required %0d", got, q,
                                           (got < 8) ? exp_port[got] : -1);
                    end else begin
                        if (!exp_wr[got]) begin
                            n_cmp++;
                            if (rd !== exp_rd[got]) begin
                                n_fail++; $display("[TB] FAIL b2b_data #%0d: got %h required %h", got, rd, exp_rd[got]);
                            end
                        end
                        exp_cyc = (got == 0) ? lat : last_ack + lat + 1;
                        n_cmp++;
                        if (cyc != exp_cyc) begin
                            n_fail++; $display("[TB] FAIL b2b_timing #%0d: got cycle %0d required %0d", got, cyc, exp_cyc);
                        end
                    end
                    last_ack = cyc;
                    got++;
                    if (nxt[q] < 4) begin
                        present(q, nxt[q]);
                        nxt[q]++;
                    end else if (q == 0) begin
                        a_memread = 0; a_memwrite = 0;
                    end else begin
                        b_memread = 0; b_memwrite = 0;
                    end
                end
            end
        end
        n_cmp++;
        if (got != 8) begin
            n_fail++; $display("[TB] FAIL b2b_count: got %0d acks required 8", got);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_arr[8'h30] = 32'hCAFE_F00D;
        for (int pass = 0; pass < 3; pass++) begin
            hang = (pass == 1);
            a_memread = 1; a_addr = 32'h30; a_sign_mask = 4'b0100;
            for (int cyc = 1; cyc <= ((pass == 1) ? TMO + 4 : 7); cyc++) begin
                @(negedge clk);
                if (pass == 1) begin
                    n_cmp++;
                    if (a_ack !== (cyc == TMO + 2) || a_err !== (cyc == TMO + 2) || mem_memread !== (cyc == 1)) begin
                        n_fail++; $display("[TB] FAIL tmo_seq c%0d: got ack=%b err=%b rd=%b required %b/%b/%b",
                                           cyc, a_ack, a_err, mem_memread, cyc == TMO + 2, cyc == TMO + 2, cyc == 1);
                    end
                end
                if (a_ack === 1'b1) begin
                    n_cmp++;
                    if (a_read_data !== ((pass == 1) ? 32'd0 : 32'hCAFE_F00D) || cyc != ((pass == 1) ? TMO + 2 : 5)) begin
                        n_fail++; $display("[TB] FAIL tmo_result pass%0d: got data=%h cycle=%0d", pass, a_read_data, cyc);
                    end
                    a_memread = 0;
                end
            end
            n_cmp++;
            if (a_memread !== 1'b0) begin
                n_fail++; a_memread = 0;
                $display("[TB] FAIL tmo_noack pass%0d: got no ack required one", pass);
            end
        end
        hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        int issue_cyc, ack_cyc;
        apply_reset();
        mem_arr[8'h40] = 32'h0BAD_C0DE;
        stall_len = 6;
        a_memread = 1; a_addr = 32'h40; a_sign_mask = 4'b0100;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_addr !== 32'd0 || mem_sign_mask !== 4'd0 || a_ack !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_clear: got addr=%h mask=%h ack=%b required 0", mem_addr, mem_sign_mask, a_ack);
        end
        @(negedge clk);
        reset_n = 1'b1;
        stall_len = 2;
        issue_cyc = 0; ack_cyc = 0;
        for (int cyc = 6; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (mem_memread === 1'b1 && issue_cyc == 0) issue_cyc = cyc;
            if (a_ack === 1'b1 && ack_cyc == 0) begin
                ack_cyc = cyc;
                a_memread = 0;
                n_cmp++;
                if (a_read_data !== 32'h0BAD_C0DE) begin
                    n_fail++; $display("[TB] FAIL midrst_data: got %h required 0badc0de", a_read_data);
                end
            end
        end
        n_cmp++;
        if (issue_cyc != 9 || ack_cyc != 13) begin
            n_fail++; $display("[TB] FAIL midrst_timing: got issue=%0d ack=%0d required 9/13", issue_cyc, ack_cyc);
        end
        a_memread = 0;
    endtask

    task automatic test_b_byte_write();
        apply_reset();
        b_memwrite = 1; b_addr = 32'h23; b_write_data = 32'hA5A5_5A5A; b_sign_mask = 4'b0000;
        a_sign_mask = 4'hF;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_memwrite !== (cyc == 1) || b_ack !== (cyc == 5) || a_ack !== 1'b0) begin
                n_fail++; $display("[TB] FAIL byte_seq c%0d: got wr=%b b_ack=%b a_ack=%b required %b/%b/0",
                                   cyc, mem_memwrite, b_ack, a_ack, cyc == 1, cyc == 5);
            end
            if (cyc <= 5) begin
                n_cmp++;
                if (mem_addr !== 32'h23 || mem_sign_mask !== 4'b0000 ||
                    mem_write_data !== 32'hA5A5_5A5A || grant_b !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL byte_hold c%0d: got addr=%h mask=%b wd=%h grant_b=%b",
                                       cyc, mem_addr, mem_sign_mask, mem_write_data, grant_b);
                end
            end
            if (cyc == 5) b_memwrite = 0;
        end
        n_cmp++;
        if (mem_arr[8'h23] !== 32'hA5A5_5A5A) begin
            n_fail++; $display("[TB] FAIL byte_store: got %h required a5a55a5a", mem_arr[8'h23]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_b_byte_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
